parking_keypad_scanner: RTL and testbench

Scans a 4×4 matrix keypad at the parking-lot entry console and returns one debounced key code per physical press through a valid/ready handshake. It is the input-side counterpart of the multiplexed display driver. It drives one keypad row at a time, the same way the display driver drives one digit at a time, and reads back the column lines. Downstream control logic consumes `key_code` to take ticket or slot commands.

---
 rtl/parking_kp_pkg.sv | 22 ++
 rtl/parking_keypad_scanner_slot_timer.sv | 16 +
 rtl/parking_keypad_scanner.sv | 103 ++++++++++
 tb/tb_parking_keypad_scanner.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/parking_kp_pkg.sv
// parking_kp_pkg: shared types, sizes and column decode for the keypad scanner
package parking_kp_pkg;
  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;
  typedef enum logic [1:0] {SCAN, CONFIRM, RELEASE} kp_state_t;
  typedef struct packed {
    logic       single;
    logic [1:0] idx;
  } kp_col_t;
  // A column sample is "single" when exactly one line is pulled low; idx names that line
  function automatic kp_col_t kp_col_index(input logic [KP_COLS-1:0] col);
    kp_col_t res;
    res.single = 1'b0;
    res.idx = 2'd0;
    for (int i = 0; i < KP_COLS; i++)
      if (col == ~(4'(1) << i)) begin
        res.single = 1'b1;
        res.idx = 2'(i);
      end
    return res;
  endfunction
endpackage

// File: rtl/parking_keypad_scanner_slot_timer.sv
// kp_slot_timer: free-running row-slot counter, tick on the last cycle of each slot
module kp_slot_timer #(
  parameter int SCAN_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int W = $clog2(SCAN_DIV);
  logic [W-1:0] count;
  assign tick = count == W'(SCAN_DIV - 1);
  // Count 0..SCAN_DIV-1 and wrap, regardless of scanner state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= tick ? '0 : count + 1'b1;
endmodule

// File: rtl/parking_keypad_scanner.sv
// parking_keypad_scanner: 4x4 keypad row scan, debounce and one-key holding register
module parking_keypad_scanner
  import parking_kp_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KP_COLS-1:0] col_in,
  output logic [KP_ROWS-1:0] row_sel,
  output logic [3:0]         key_code,
  output logic               key_valid,
  input  logic               key_ready,
  output logic               key_drop,
  output logic               key_down
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  logic [KP_COLS-1:0] col_m, col_s;
  logic               tick, hit, accept;
  kp_state_t          state;
  logic [1:0]         r, nr, cand;
  logic [CW-1:0]      cnt, cnt_rel;
  kp_col_t            samp;

  kp_slot_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // Two-flop synchronizer; idle keypad reads all ones
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {col_m, col_s} <= {8'hFF};
    else {col_m, col_s} <= {col_in, col_m};

  // Decode the current sample and decide whether this tick completes a press
  always_comb begin
    samp = kp_col_index(col_s);
    nr = r + 2'd1;
    hit = samp.single & (state == SCAN || samp.idx == cand);
    accept = tick & hit & ((state == SCAN && DEBOUNCE == 1) ||
                           (state == CONFIRM && cnt == CW'(DEBOUNCE - 1)));
    cnt_rel = col_s == 4'hF ? (cnt == CW'(DEBOUNCE) ? cnt : cnt + 1'b1) : '0;
  end

  // Scan/confirm/release sequencing; release counting restarts from zero on acceptance
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= SCAN;
      r <= 2'd0;
      row_sel <= 4'b1110;
      cnt <= '0;
      cand <= 2'd0;
      key_down <= 1'b0;
    end else if (tick) begin
      case (state)
        SCAN:
          if (samp.single) begin
            cand <= samp.idx;
            cnt <= accept ? '0 : CW'(1);
            state <= accept ? RELEASE : CONFIRM;
            key_down <= accept;
          end else begin
            r <= nr;
            row_sel <= ~(4'b0001 << nr);
          end
        CONFIRM:
          if (!hit) begin
            state <= SCAN;
            r <= nr;
            row_sel <= ~(4'b0001 << nr);
          end else if (accept) begin
            state <= RELEASE;
            cnt <= '0;
            key_down <= 1'b1;
          end else cnt <= cnt + 1'b1;
        RELEASE:
          if (cnt_rel == CW'(DEBOUNCE)) begin
            state <= SCAN;
            cnt <= '0;
            key_down <= 1'b0;
            r <= nr;
            row_sel <= ~(4'b0001 << nr);
          end else cnt <= cnt_rel;
        default: state <= SCAN;
      endcase
    end

  // One-entry holding register with valid/ready handshake and drop pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      key_code <= 4'd0;
      key_valid <= 1'b0;
      key_drop <= 1'b0;
    end else begin
      key_drop <= accept & key_valid & ~key_ready;
      if (accept & (~key_valid | key_ready)) begin
        key_code <= {r, samp.idx};
        key_valid <= 1'b1;
      end else if (key_ready) key_valid <= 1'b0;
    end
endmodule

// File: tb/tb_parking_keypad_scanner.sv
// tb_parking_keypad_scanner: directed tests of scanning, debounce, handshake and reset
module tb_parking_keypad_scanner;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_ready = 1'b0;
  logic [3:0]  col_in, row_sel, key_code;
  logic        key_valid, key_drop, key_down;
  logic [15:0] kmask = '0;
  int checks = 0;
  int fails = 0;

  parking_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .col_in   (col_in),
    .row_sel  (row_sel),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_drop (key_drop),
    .key_down (key_down)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed key pulls its column low while its row is driven
  always_comb begin
    col_in = 4'hF;
    for (int i = 0; i < 4; i++)
      if (!row_sel[i]) col_in = col_in & ~kmask[4*i +: 4];
  end

  task automatic press(input int rr, input int cc);
    kmask[4*rr + cc] = 1'b1;
  endtask

  task automatic release_all();
    kmask = '0;
  endtask

  task automatic wait_row(input logic [3:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (row_sel === target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    rst_n = 1'b0;
    key_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (row_sel !== 4'b1110) begin fails++; $display("FAIL reset_row_sel got %b want 1110", row_sel); end
    checks++; if (key_valid !== 1'b0) begin fails++; $display("FAIL reset_key_valid got %b want 0", key_valid); end
    checks++; if (key_code !== 4'h0) begin fails++; $display("FAIL reset_key_code got %h want 0", key_code); end
    checks++; if (key_down !== 1'b0) begin fails++; $display("FAIL reset_key_down got %b want 0", key_down); end
    checks++; if (key_drop !== 1'b0) begin fails++; $display("FAIL reset_key_drop got %b want 0", key_drop); end
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp = ~(4'b0001 << ((k / 4) % 4));
      checks++; if (row_sel !== exp) begin fails++; $display("FAIL idle_rotate k=%0d got %b want %b", k, row_sel, exp); end
      checks++; if (key_valid !== 1'b0) begin fails++; $display("FAIL idle_valid k=%0d got %b want 0", k, key_valid); end
    end
  endtask

  task automatic test_press();
    bit ok;
    int pulses = 0;
    int down_low = 0;
    press(2, 1);
    wait_row(4'b1011, ok);
    checks++; if (!ok) begin fails++; $display("FAIL press_reach_row2 got timeout want row 1011"); end
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      checks++; if (key_valid !== (k == 12)) begin fails++; $display("FAIL press_valid_timing k=%0d got %b want %b", k, key_valid, k == 12); end
      if (k == 11) begin
        checks++; if (key_down !== 1'b0) begin fails++; $display("FAIL press_down_early got %b want 0", key_down); end
      end
      if (k == 12) begin
        checks++; if (key_code !== 4'h9) begin fails++; $display("FAIL press_code got %h want 9", key_code); end
        checks++; if (key_down !== 1'b1) begin fails++; $display("FAIL press_down got %b want 1", key_down); end
      end
    end
    for (int k = 14; k <= 200; k++) begin
      @(negedge clk);
      if (key_valid) pulses++;
      if (!key_down) down_low++;
    end
    checks++; if (pulses !== 0) begin fails++; $display("FAIL press_no_repeat got %0d want 0", pulses); end
    checks++; if (down_low !== 0) begin fails++; $display("FAIL press_down_held got %0d low cycles want 0", down_low); end
    release_all();
    for (int k = 201; k <= 212; k++) begin
      @(negedge clk);
      if (k == 211) begin
        checks++; if (key_down !== 1'b1) begin fails++; $display("FAIL release_down_hold got %b want 1", key_down); end
        checks++; if (row_sel !== 4'b1011) begin fails++; $display("FAIL release_row_frozen got %b want 1011", row_sel); end
      end
      if (k == 212) begin
        checks++; if (key_down !== 1'b0) begin fails++; $display("FAIL release_down_clear got %b want 0", key_down); end
        checks++; if (row_sel !== 4'b0111) begin fails++; $display("FAIL release_row_next got %b want 0111", row_sel); end
      end
    end
  endtask

  task automatic test_bounce();
    bit ok;
    int bad = 0;
    wait_row(4'b1011, ok);
    checks++; if (!ok) begin fails++; $display("FAIL bounce_reach_row2 got timeout want row 1011"); end
    press(2, 1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (key_valid || key_down) bad++;
      if (k == 4) release_all();
      if (k == 7) begin
        checks++; if (row_sel !== 4'b1011) begin fails++; $display("FAIL bounce_row_frozen got %b want 1011", row_sel); end
      end
      if (k == 8) begin
        checks++; if (row_sel !== 4'b0111) begin fails++; $display("FAIL bounce_row_resume got %b want 0111", row_sel); end
      end
    end
    checks++; if (bad !== 0) begin fails++; $display("FAIL bounce_no_report got %0d active cycles want 0", bad); end
  endtask

  task automatic test_double();
    logic [3:0] prev;
    int changes = 0;
    int bad = 0;
    press(1, 0);
    press(1, 2);
    prev = row_sel;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (row_sel !== prev) changes++;
      prev = row_sel;
      if (key_valid || key_down) bad++;
    end
    release_all();
    checks++; if (changes !== 16) begin fails++; $display("FAIL double_scan_continues got %0d row changes want 16", changes); end
    checks++; if (bad !== 0) begin fails++; $display("FAIL double_no_report got %0d active cycles want 0", bad); end
  endtask

  task automatic test_drop();
    bit ok;
    int drops = 0;
    key_ready = 1'b0;
    press(2, 1);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin @(negedge clk); ok = key_valid; end
    checks++; if (!ok) begin fails++; $display("FAIL drop_first_valid got timeout want key_valid 1"); end
    checks++; if (key_code !== 4'h9) begin fails++; $display("FAIL drop_first_code got %h want 9", key_code); end
    release_all();
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin @(negedge clk); ok = !key_down; end
    checks++; if (!ok) begin fails++; $display("FAIL drop_first_release got timeout want key_down 0"); end
    press(0, 3);
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (key_drop) drops++;
    end
    checks++; if (drops !== 1) begin fails++; $display("FAIL drop_pulse_count got %0d want 1", drops); end
    checks++; if (key_code !== 4'h9) begin fails++; $display("FAIL drop_code_kept got %h want 9", key_code); end
    checks++; if (key_valid !== 1'b1) begin fails++; $display("FAIL drop_valid_kept got %b want 1", key_valid); end
    release_all();
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin @(negedge clk); ok = !key_down; end
    checks++; if (!ok) begin fails++; $display("FAIL drop_second_release got timeout want key_down 0"); end
  endtask

  task automatic test_async_reset();
    bit ok;
    logic [3:0] exp;
    wait_row(4'b1110, ok);
    checks++; if (!ok) begin fails++; $display("FAIL areset_reach_row0 got timeout want row 1110"); end
    press(3, 2);
    wait_row(4'b0111, ok);
    checks++; if (!ok) begin fails++; $display("FAIL areset_reach_row3 got timeout want row 0111"); end
    repeat (6) @(negedge clk);
    checks++; if (row_sel !== 4'b0111) begin fails++; $display("FAIL areset_confirm_row got %b want 0111", row_sel); end
    checks++; if (key_valid !== 1'b1) begin fails++; $display("FAIL areset_pending_valid got %b want 1", key_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (row_sel !== 4'b1110) begin fails++; $display("FAIL areset_row_sel got %b want 1110", row_sel); end
    checks++; if (key_valid !== 1'b0) begin fails++; $display("FAIL areset_key_valid got %b want 0", key_valid); end
    checks++; if (key_code !== 4'h0) begin fails++; $display("FAIL areset_key_code got %h want 0", key_code); end
    checks++; if (key_down !== 1'b0) begin fails++; $display("FAIL areset_key_down got %b want 0", key_down); end
    release_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp = ~(4'b0001 << (k / 4));
      checks++; if (row_sel !== exp) begin fails++; $display("FAIL areset_restart k=%0d got %b want %b", k, row_sel, exp); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_double();
    test_drop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule
